// File: rtl/spi_ram_master.sv
// rtl/spi_ram_master.sv - SPI master sequencing single-byte reads/writes to an SPI RAM slave
//
// Purpose: accepts one read or write request at a time and splits it into an
// address frame and a data frame. Each frame is a command-check cycle followed by
// {cmd[1:0], byte[7:0]} sent MSB first. Reads then wait RD_WAIT turnaround cycles
// and capture 8 MISO bits, MSB first.
//
// Parameters:
//   GAP      SS_n high cycles between address and data frames (1..15)
//   RD_WAIT  slave turnaround cycles before the first MISO bit (0..15)
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_wr, req_addr, req_wdata   request fields, latched at accept
//   rsp_valid, rsp_rdata          one-cycle completion strobe and read data
//   SS_n, MOSI, MISO              SPI pins, all registered on clk

module spi_ram_master #(
  parameter int GAP     = 1,
  parameter int RD_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_FRM,
    S_GAP,
    S_DATA_FRM,
    S_TURN,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [4:0] FRM_LAST = 5'd10;
  localparam logic [4:0] CAP_LAST = 5'd7;
  localparam logic [4:0] GAP_LAST = 5'(GAP - 1);
  localparam logic [4:0] RD_LAST  = 5'(RD_WAIT - 1);

  state_t     state;
  logic [4:0] cnt;
  logic       wr_q;
  logic [7:0] wdata_q;
  logic [9:0] shreg;
  logic [7:0] rx;

  // Outputs are computed for the cycle that follows each edge, so every
  // branch below sets SS_n/MOSI for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 5'd0;
      wr_q      <= 1'b0;
      wdata_q   <= 8'h00;
      shreg     <= 10'h000;
      rx        <= 8'h00;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            wr_q      <= req_wr;
            wdata_q   <= req_wdata;
            shreg     <= {(req_wr ? 2'b00 : 2'b10), req_addr};
            state     <= S_ADDR_FRM;
            cnt       <= 5'd0;
            req_ready <= 1'b0;
            SS_n      <= 1'b0;
            MOSI      <= 1'b0;  // frame cycle 0 is the slave's command-check cycle
          end
        end

        S_ADDR_FRM, S_DATA_FRM: begin
          if (cnt == FRM_LAST) begin
            cnt  <= 5'd0;
            MOSI <= 1'b0;
            if (state == S_ADDR_FRM) begin
              state <= S_GAP;
              SS_n  <= 1'b1;
            end else if (wr_q) begin
              state     <= S_DONE;
              SS_n      <= 1'b1;
              rsp_valid <= 1'b1;
            end else begin
              state <= (RD_WAIT == 0) ? S_CAPTURE : S_TURN;
            end
          end else begin
            cnt   <= cnt + 5'd1;
            MOSI  <= shreg[9];
            shreg <= {shreg[8:0], 1'b0};
          end
        end

        S_GAP: begin
          if (cnt == GAP_LAST) begin
            state <= S_DATA_FRM;
            cnt   <= 5'd0;
            SS_n  <= 1'b0;
            shreg <= {(wr_q ? 2'b01 : 2'b11), (wr_q ? wdata_q : 8'h00)};
          end else begin
            cnt <= cnt + 5'd1;
          end
        end

        S_TURN: begin
          if (cnt == RD_LAST) begin
            state <= S_CAPTURE;
            cnt   <= 5'd0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end

        S_CAPTURE: begin
          rx <= {rx[6:0], MISO};
          if (cnt == CAP_LAST) begin
            state     <= S_DONE;
            cnt       <= 5'd0;
            SS_n      <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_rdata <= {rx[6:0], MISO};
          end else begin
            cnt <= cnt + 5'd1;
          end
        end

        S_DONE: begin
          state     <= S_IDLE;
          cnt       <= 5'd0;
          req_ready <= 1'b1;
        end

        default: begin
          state <= S_IDLE;
          cnt   <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_master.sv
// tb/tb_spi_ram_master.sv - scoreboard bench for spi_ram_master with an SPI RAM slave model

module tb_spi_ram_master;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [1:0] rsp_valid;
  logic [1:0] ss_n;
  logic [1:0] mosi;
  logic [1:0] miso = 2'b00;
  logic       req_wr;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic [7:0] rdata0;
  logic [7:0] rdata1;

  always #5 clk = ~clk;

  spi_ram_master dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rdata0),
    .SS_n(ss_n[0]), .MOSI(mosi[0]), .MISO(miso[0])
  );

  spi_ram_master #(.GAP(3), .RD_WAIT(0)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rdata1),
    .SS_n(ss_n[1]), .MOSI(mosi[1]), .MISO(miso[1])
  );

  typedef struct packed {
    logic [15:0] lat;
    logic [7:0]  rd;
    logic [9:0]  f0;
    logic [9:0]  f1;
    logic [7:0]  gap;
  } txn_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  txn_t exp_q[$];

  // Monitor/slave-model observations (written only by the negedge block)
  int         acc_q[$];
  int         rsp_cyc_q[$];
  logic [7:0] rsp_dat_q[$];
  logic [9:0] frm_q[$];
  int         gap_q[$];
  int         ready_busy = 0;
  logic [7:0] mem[256];
  bit         init_done = 1'b0;
  int         pos[2] = '{0, 0};
  int         hi_run[2] = '{0, 0};
  logic [9:0] sh[2];
  logic [7:0] waddr[2];
  logic [7:0] raddr[2];
  bit         rd_act[2] = '{1'b0, 1'b0};

  function automatic logic [7:0] preload(input int k);
    if (k == 15) return 8'h14;
    return 8'(k * 7 + 3);
  endfunction

  function automatic string fmt(input txn_t t);
    return $sformatf("lat=%0d rd=%h f0=%b f1=%b gap=%0d", t.lat, t.rd, t.f0, t.f1, t.gap);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // SPI RAM slave model: frame cycle 0 is command check, cycles 1..10 carry the
  // frame bits; after a read-data frame it waits the turnaround then drives
  // the addressed byte MSB first, one bit per cycle.
  always @(negedge clk) begin
    int p;
    int rw;
    logic [7:0] b;
    if (!init_done) begin
      for (int k = 0; k < 256; k++) mem[k] = preload(k);
      init_done = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      rw = (i == 0) ? 1 : 0;
      if (!rst && req_valid[i] && req_ready[i]) acc_q.push_back(cyc);
      if (rsp_valid[i]) begin
        rsp_cyc_q.push_back(cyc);
        rsp_dat_q.push_back(i == 0 ? rdata0 : rdata1);
      end
      if (req_ready[i] && (ss_n[i] == 1'b0 || rsp_valid[i])) ready_busy++;
      if (ss_n[i] !== 1'b0) begin
        pos[i]    = 0;
        rd_act[i] = 1'b0;
        hi_run[i] = hi_run[i] + 1;
        miso[i]   = 1'b0;
      end else begin
        if (hi_run[i] > 0) gap_q.push_back(hi_run[i]);
        hi_run[i] = 0;
        p = pos[i];
        if (p >= 1 && p <= 10) sh[i] = {sh[i][8:0], mosi[i]};
        if (p == 10) begin
          frm_q.push_back(sh[i]);
          case (sh[i][9:8])
            2'b00: waddr[i] = sh[i][7:0];
            2'b01: mem[waddr[i]] = sh[i][7:0];
            2'b10: raddr[i] = sh[i][7:0];
            default: rd_act[i] = 1'b1;
          endcase
        end
        if (rd_act[i] && p >= 11 + rw && p <= 18 + rw) begin
          b = mem[raddr[i]];
          miso[i] = b[7 - (p - 11 - rw)];
        end else begin
          miso[i] = 1'b0;
        end
        pos[i] = p + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Drives a request and waits (bounded) until the monitor sees it accepted.
  task automatic issue(input int i, input bit wr, input logic [7:0] a, input logic [7:0] d,
                       input bit hold);
    int n0 = acc_q.size();
    int n = 0;
    req_wr       = wr;
    req_addr     = a;
    req_wdata    = d;
    req_valid[i] = 1'b1;
    while (acc_q.size() <= n0 && n < 300) begin
      step();
      n++;
    end
    if (!hold) req_valid[i] = 1'b0;
  endtask

  // Waits (bounded) for response ri and gathers what was observed for it.
  task automatic collect(input int ai, input int ri, input int fi, input int gi, output txn_t o);
    int n = 0;
    while (rsp_cyc_q.size() <= ri && n < 300) begin
      step();
      n++;
    end
    o = '1;
    if (rsp_cyc_q.size() > ri && acc_q.size() > ai) begin
      o.lat = 16'(rsp_cyc_q[ri] - acc_q[ai]);
      o.rd  = rsp_dat_q[ri];
    end
    if (frm_q.size() > fi)     o.f0  = frm_q[fi];
    if (frm_q.size() > fi + 1) o.f1  = frm_q[fi + 1];
    if (gap_q.size() > gi)     o.gap = 8'(gap_q[gi]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    req_wr = 1'b1; req_addr = 8'h80; req_wdata = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if ({ss_n[0], mosi[0], req_ready[0], rsp_valid[0], rdata0} !== {4'b1010, 8'h00}) begin
        errors++;
        $display("FAIL reset_dut0 cyc%0d: got ss=%b mosi=%b rdy=%b rv=%b rd=%h, expected 1 0 1 0 00",
                 c, ss_n[0], mosi[0], req_ready[0], rsp_valid[0], rdata0);
      end
      checks++;
      if ({ss_n[1], mosi[1], req_ready[1], rsp_valid[1], rdata1} !== {4'b1010, 8'h00}) begin
        errors++;
        $display("FAIL reset_dut1 cyc%0d: got ss=%b mosi=%b rdy=%b rv=%b rd=%h, expected 1 0 1 0 00",
                 c, ss_n[1], mosi[1], req_ready[1], rsp_valid[1], rdata1);
      end
    end
    rst = 1'b0;
    req_valid = 2'b00;
    repeat (4) step();
    checks++;
    if (acc_q.size() !== 0 || ss_n !== 2'b11 || frm_q.size() !== 0) begin
      errors++;
      $display("FAIL reset_no_frame: got accepts=%0d ss=%b frames=%0d, expected 0 11 0",
               acc_q.size(), ss_n, frm_q.size());
    end
  endtask

  task automatic test_write();
    txn_t o, e;
    int ai = acc_q.size(), ri = rsp_cyc_q.size(), fi = frm_q.size(), gi = gap_q.size();
    exp_q.push_back('{lat: 16'd24, rd: 8'h00, f0: {2'b00, 8'h80}, f1: {2'b01, 8'hFF}, gap: 8'd1});
    issue(0, 1'b1, 8'h80, 8'hFF, 1'b0);
    collect(ai, ri, fi, gi + 1, o);
    e = exp_q.pop_front();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL write_txn: got %s, expected %s", fmt(o), fmt(e));
    end
    checks++;
    if (mem[128] !== 8'hFF) begin
      errors++;
      $display("FAIL write_mem: got mem[128]=%h, expected ff", mem[128]);
    end
  endtask

  task automatic test_read();
    txn_t o, e;
    int ai = acc_q.size(), ri = rsp_cyc_q.size(), fi = frm_q.size(), gi = gap_q.size();
    exp_q.push_back('{lat: 16'd33, rd: 8'h14, f0: {2'b10, 8'h0F}, f1: {2'b11, 8'h00}, gap: 8'd1});
    issue(0, 1'b0, 8'h0F, 8'hAA, 1'b0);
    collect(ai, ri, fi, gi + 1, o);
    e = exp_q.pop_front();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL read_txn: got %s, expected %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_back_to_back();
    txn_t o1, o2, e;
    int sep;
    int ai = acc_q.size(), ri = rsp_cyc_q.size(), fi = frm_q.size(), gi = gap_q.size();
    int busy0 = ready_busy;
    exp_q.push_back('{lat: 16'd24, rd: 8'h14, f0: {2'b00, 8'h33}, f1: {2'b01, 8'hA5}, gap: 8'd1});
    exp_q.push_back('{lat: 16'd33, rd: 8'hA5, f0: {2'b10, 8'h33}, f1: {2'b11, 8'h00}, gap: 8'd1});
    issue(0, 1'b1, 8'h33, 8'hA5, 1'b1);
    // Request fields change right after accept; the write must use latched values.
    issue(0, 1'b0, 8'h33, 8'h5C, 1'b0);
    collect(ai, ri, fi, gi + 1, o1);
    collect(ai + 1, ri + 1, fi + 2, gi + 3, o2);
    e = exp_q.pop_front();
    checks++;
    if (o1 !== e) begin
      errors++;
      $display("FAIL b2b_write: got %s, expected %s", fmt(o1), fmt(e));
    end
    e = exp_q.pop_front();
    checks++;
    if (o2 !== e) begin
      errors++;
      $display("FAIL b2b_read: got %s, expected %s", fmt(o2), fmt(e));
    end
    sep = (acc_q.size() > ai + 1 && rsp_cyc_q.size() > ri) ? acc_q[ai + 1] - rsp_cyc_q[ri] : -1;
    checks++;
    if (sep !== 1) begin
      errors++;
      $display("FAIL b2b_accept_spacing: got %0d, expected 1", sep);
    end
    checks++;
    if (gap_q.size() <= gi + 2 || gap_q[gi + 2] !== 2) begin
      errors++;
      $display("FAIL b2b_ss_high_between: got %0d, expected 2",
               gap_q.size() > gi + 2 ? gap_q[gi + 2] : -1);
    end
    checks++;
    if (ready_busy !== busy0) begin
      errors++;
      $display("FAIL b2b_ready_while_busy: got %0d cycles, expected 0", ready_busy - busy0);
    end
  endtask

  task automatic test_reset_mid_frame();
    txn_t o, e;
    int rn, ai, ri, fi, gi;
    issue(0, 1'b1, 8'h5A, 8'h3C, 1'b0);
    repeat (17) step();  // now in data frame bit 5
    checks++;
    if (ss_n[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_in_frame: got ss=%b, expected 0", ss_n[0]);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({ss_n[0], mosi[0], req_ready[0], rsp_valid[0], rdata0} !== {4'b1010, 8'h00}) begin
      errors++;
      $display("FAIL midrst_outputs: got ss=%b mosi=%b rdy=%b rv=%b rd=%h, expected 1 0 1 0 00",
               ss_n[0], mosi[0], req_ready[0], rsp_valid[0], rdata0);
    end
    rst = 1'b0;
    rn = rsp_cyc_q.size();
    repeat (40) step();
    checks++;
    if (rsp_cyc_q.size() !== rn) begin
      errors++;
      $display("FAIL midrst_no_rsp: got %0d responses, expected %0d", rsp_cyc_q.size(), rn);
    end
    checks++;
    if (mem[8'h5A] !== preload(8'h5A)) begin
      errors++;
      $display("FAIL midrst_mem_untouched: got %h, expected %h", mem[8'h5A], preload(8'h5A));
    end
    ai = acc_q.size(); ri = rsp_cyc_q.size(); fi = frm_q.size(); gi = gap_q.size();
    exp_q.push_back('{lat: 16'd24, rd: 8'h00, f0: {2'b00, 8'h21}, f1: {2'b01, 8'h96}, gap: 8'd1});
    issue(0, 1'b1, 8'h21, 8'h96, 1'b0);
    collect(ai, ri, fi, gi + 1, o);
    e = exp_q.pop_front();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL midrst_next_write: got %s, expected %s", fmt(o), fmt(e));
    end
    checks++;
    if (mem[8'h21] !== 8'h96) begin
      errors++;
      $display("FAIL midrst_next_mem: got %h, expected 96", mem[8'h21]);
    end
  endtask

  task automatic test_gap3_rdwait0();
    txn_t o, e;
    int ai = acc_q.size(), ri = rsp_cyc_q.size(), fi = frm_q.size(), gi = gap_q.size();
    exp_q.push_back('{lat: 16'd34, rd: preload(8'h42), f0: {2'b10, 8'h42}, f1: {2'b11, 8'h00},
                      gap: 8'd3});
    issue(1, 1'b0, 8'h42, 8'h00, 1'b0);
    collect(ai, ri, fi, gi + 1, o);
    e = exp_q.pop_front();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL gap3_read: got %s, expected %s", fmt(o), fmt(e));
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    req_wr = 1'b0;
    req_addr = 8'h00;
    req_wdata = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid_frame();
    test_gap3_rdwait0();
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
